// File: rtl/nq_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nq_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam int              PC_STEP_DEF  = 2;
  localparam logic [PC_W-1:0] RESET_PC_DEF = 16'h0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of imem request/response, branch redirect, stall and fetch output signals.
// Latency: n/a (wires only).
// Backpressure: stall from downstream; imem_ready from memory.
interface fetch_stage_if;
  import nq_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               stall;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    PC_n;

  // Fetch-stage side
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, PC_n,
    input  imem_ready, imem_data, br_taken, br_target, stall
  );

  // Environment side: memory, branch unit and downstream stage
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, PC_n,
    output imem_ready, imem_data, br_taken, br_target, stall
  );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter used for fetch performance statistics (built only with FETCH_PERF_CNT_EN).
// Latency: count visible one cycle after the increment cycle.
// Backpressure: none; sticks at all-ones instead of wrapping.
`ifdef FETCH_PERF_CNT_EN
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, imem request, registered instruction/next-PC output.
// Latency: 1 cycle from accepted imem request (imem_req && imem_ready) to if_valid.
// Backpressure: stall with a valid output holds everything and parks in HOLD; one bubble on release.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt outputs.
module fetch_stage
  import nq_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              PC_STEP  = PC_STEP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fe
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_n_q, pc_n_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    pc_inc;
  logic               hold_out;
  logic               req;
  logic               accept;

  // Modulo-2^16 increment falls out of the fixed-width add
  assign pc_inc   = pc_q + PC_W'(PC_STEP);
  // Downstream refuses the instruction we are presenting
  assign hold_out = valid_q && fe.stall;
  assign accept   = req && fe.imem_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a taken branch always redirects into REQ, even from IDLE or HOLD
  always_comb begin
    state_d = state_q;
    if (fe.br_taken) begin
      state_d = FS_REQ;
    end else begin
      case (state_q)
        FS_IDLE: state_d = FS_REQ;
        FS_REQ:  if (hold_out) state_d = FS_HOLD;
        FS_HOLD: if (!fe.stall) state_d = FS_REQ;
        default: state_d = FS_IDLE;
      endcase
    end
  end

  // Request only in REQ, never while stalled on a valid output, redirecting or in reset
  always_comb begin
    req = (state_q == FS_REQ) && !hold_out && !fe.br_taken && !rst;
  end

  // Datapath next-state: branch beats stall beats fetch
  always_comb begin
    pc_d    = pc_q;
    pc_n_d  = pc_n_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (fe.br_taken) begin
      pc_d    = {fe.br_target[PC_W-1:1], 1'b0};
      valid_d = 1'b0;
    end else if (accept) begin
      instr_d = fe.imem_data;
      pc_n_d  = pc_inc;
      pc_d    = pc_inc;
      valid_d = 1'b1;
    end else if (!hold_out) begin
      // Output consumed (or nothing was there) and no new fetch landed
      valid_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc_n_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc_n_q  <= pc_n_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign fe.imem_req  = req;
  assign fe.imem_addr = pc_q;
  assign fe.if_valid  = valid_q;
  assign fe.if_instr  = instr_q;
  assign fe.PC_n      = pc_n_q;

`ifdef FETCH_PERF_CNT_EN
  // Accepted fetches are never flushed: a branch suppresses the request in the same cycle
  sat_counter #(.W(16)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept),
    .cnt_o (fetch_cnt)
  );

  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (hold_out),
    .cnt_o (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;
  import nq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        t_ready;
  logic [15:0] t_data;
  logic        t_br;
  logic [15:0] t_tgt;
  logic        t_stall;

  fetch_stage_if f1();
  fetch_stage_if f2();

  assign f1.imem_ready = t_ready;
  assign f1.imem_data  = t_data;
  assign f1.br_taken   = t_br;
  assign f1.br_target  = t_tgt;
  assign f1.stall      = t_stall;
  assign f2.imem_ready = t_ready;
  assign f2.imem_data  = t_data;
  assign f2.br_taken   = t_br;
  assign f2.br_target  = t_tgt;
  assign f2.stall      = t_stall;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fc1, sc1, fc2, sc2;
`endif

  fetch_stage #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .fe(f1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fc1), .stall_cnt(sc1)
`endif
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .PC_STEP(2)) dut_w (
    .clk(clk), .rst(rst), .fe(f2)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt(fc2), .stall_cnt(sc2)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model of the dut instance (RESET_PC=0, step 2), in terms of the observable rules
  bit          m_idle;   // first cycle after reset: no request
  bit          m_stl;    // last cycle stalled on a valid output: no request this cycle (HOLD / bubble)
  bit          m_valid;
  logic [15:0] m_pc, m_instr, m_pcn;
  int          m_fcnt, m_scnt;

  // Values sampled before the clock edge of the most recent step
  bit          obs_req, obs_req2, exp_req;
  logic [15:0] obs_addr, obs_addr2, exp_addr;

  // One clock: drive inputs after the falling edge, sample the request, update the model at the edge
  task automatic step(input bit r, input bit rdy, input logic [15:0] d,
                      input bit br, input logic [15:0] tgt, input bit st);
    bit acc, stl_new;
    @(negedge clk);
    rst = r; t_ready = rdy; t_data = d; t_br = br; t_tgt = tgt; t_stall = st;
    #1;
    obs_req   = f1.imem_req;
    obs_addr  = f1.imem_addr;
    obs_req2  = f2.imem_req;
    obs_addr2 = f2.imem_addr;
    exp_req   = !r && !m_idle && !m_stl && !(m_valid && st) && !br;
    exp_addr  = m_pc;
    acc       = exp_req && rdy;
    @(posedge clk);
    if (r) begin
      m_pc = 16'h0000; m_idle = 1'b1; m_stl = 1'b0; m_valid = 1'b0;
      m_instr = 16'h0; m_pcn = 16'h0; m_fcnt = 0; m_scnt = 0;
    end else begin
      if (acc && m_fcnt < 65535) m_fcnt++;
      if (m_valid && st && m_scnt < 65535) m_scnt++;
      if (br) begin
        m_pc = tgt & 16'hFFFE; m_valid = 1'b0; m_stl = 1'b0;
      end else begin
        stl_new = m_valid && st;
        if (acc) begin
          m_instr = d; m_pcn = m_pc + 16'd2; m_pc = m_pc + 16'd2; m_valid = 1'b1;
        end else if (!(m_valid && st)) begin
          m_valid = 1'b0;
        end
        m_stl = stl_new;
      end
      m_idle = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 16'($urandom), 0, 16'h0, 0);
    step(1, 1, 16'($urandom), 0, 16'h0, 1);
    n_tot++; if (obs_req !== 1'b0) $display("FAIL rst_req got=%0b exp=0", obs_req); else n_pass++;
    n_tot++; if (f1.if_valid !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", f1.if_valid); else n_pass++;
    n_tot++; if (f1.if_instr !== 16'h0) $display("FAIL rst_instr got=%h exp=0000", f1.if_instr); else n_pass++;
    n_tot++; if (f1.PC_n !== 16'h0) $display("FAIL rst_pcn got=%h exp=0000", f1.PC_n); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_req !== 1'b0) $display("FAIL idle_req got=%0b exp=0", obs_req); else n_pass++;
    n_tot++; if (f1.if_valid !== 1'b0) $display("FAIL idle_valid got=%0b exp=0", f1.if_valid); else n_pass++;
  endtask

  task automatic test_seq();
    logic [15:0] d;
    step(1, 0, 16'h0, 0, 16'h0, 0);
    step(0, 1, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      step(0, 1, d, 0, 16'h0, 0);
      n_tot++; if (obs_req !== 1'b1 || obs_addr !== 16'(2 * i))
        $display("FAIL seq_addr[%0d] got=%0b/%h exp=1/%h", i, obs_req, obs_addr, 16'(2 * i)); else n_pass++;
      n_tot++; if (f1.if_valid !== 1'b1 || f1.PC_n !== 16'(2 * i + 2) || f1.if_instr !== d)
        $display("FAIL seq_out[%0d] got=%0b/%h/%h exp=1/%h/%h", i, f1.if_valid, f1.PC_n, f1.if_instr, 16'(2 * i + 2), d); else n_pass++;
    end
  endtask

  task automatic test_ready_low();
    logic [15:0] d;
    step(0, 0, 16'h0, 1, 16'h0010, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'($urandom), 0, 16'h0, 0);
      n_tot++; if (obs_req !== 1'b1 || obs_addr !== 16'h0010 || f1.if_valid !== 1'b0)
        $display("FAIL rdylow[%0d] got=%0b/%h/%0b exp=1/0010/0", i, obs_req, obs_addr, f1.if_valid); else n_pass++;
    end
    d = 16'($urandom);
    step(0, 1, d, 0, 16'h0, 0);
    n_tot++; if (f1.if_valid !== 1'b1 || f1.PC_n !== 16'h0012 || f1.if_instr !== d)
      $display("FAIL rdylow_done got=%0b/%h/%h exp=1/0012/%h", f1.if_valid, f1.PC_n, f1.if_instr, d); else n_pass++;
  endtask

  task automatic test_stall();
    step(0, 0, 16'h0, 1, 16'h0020, 0);
    step(0, 1, 16'h1234, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'($urandom), 0, 16'h0, 1);
      n_tot++; if (obs_req !== 1'b0 || f1.if_valid !== 1'b1 || f1.if_instr !== 16'h1234 || f1.PC_n !== 16'h0022)
        $display("FAIL stall_hold[%0d] got=%0b/%0b/%h/%h exp=0/1/1234/0022", i, obs_req, f1.if_valid, f1.if_instr, f1.PC_n); else n_pass++;
      n_tot++; if (dut.state_q !== FS_HOLD)
        $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, dut.state_q, FS_HOLD); else n_pass++;
    end
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_req !== 1'b0 || f1.if_valid !== 1'b0)
      $display("FAIL stall_bubble got=%0b/%0b exp=0/0", obs_req, f1.if_valid); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_req !== 1'b1 || obs_addr !== 16'h0022 || f1.PC_n !== 16'h0024)
      $display("FAIL stall_resume got=%0b/%h/%h exp=1/0022/0024", obs_req, obs_addr, f1.PC_n); else n_pass++;
  endtask

  task automatic test_branch();
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    step(0, 1, 16'($urandom), 0, 16'h0, 1);
    step(0, 1, 16'($urandom), 1, 16'h0041, 1);
    n_tot++; if (obs_req !== 1'b0 || f1.if_valid !== 1'b0)
      $display("FAIL br_flush got=%0b/%0b exp=0/0", obs_req, f1.if_valid); else n_pass++;
    step(0, 0, 16'h0, 0, 16'h0, 1);
    n_tot++; if (obs_req !== 1'b1 || obs_addr !== 16'h0040)
      $display("FAIL br_addr got=%0b/%h exp=1/0040", obs_req, obs_addr); else n_pass++;
  endtask

  task automatic test_wrap();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    step(0, 1, 16'h0, 0, 16'h0, 0);
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_req2 !== 1'b1 || obs_addr2 !== 16'hFFFE || f2.PC_n !== 16'h0000 || f2.if_valid !== 1'b1)
      $display("FAIL wrap_first got=%0b/%h/%h/%0b exp=1/fffe/0000/1", obs_req2, obs_addr2, f2.PC_n, f2.if_valid); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_addr2 !== 16'h0000 || f2.PC_n !== 16'h0002)
      $display("FAIL wrap_next got=%h/%h exp=0000/0002", obs_addr2, f2.PC_n); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    step(0, 1, 16'($urandom), 0, 16'h0, 1);
    step(1, 1, 16'($urandom), 0, 16'h0, 1);
    n_tot++; if (f1.if_valid !== 1'b0 || f1.if_instr !== 16'h0 || f1.PC_n !== 16'h0)
      $display("FAIL midrst got=%0b/%h/%h exp=0/0000/0000", f1.if_valid, f1.if_instr, f1.PC_n); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (f1.if_valid !== 1'b0) $display("FAIL midrst_idle got=%0b exp=0", f1.if_valid); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    n_tot++; if (obs_addr !== 16'h0000 || f1.PC_n !== 16'h0002)
      $display("FAIL midrst_restart got=%h/%h exp=0000/0002", obs_addr, f1.PC_n); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, pc;
    step(1, 0, 16'h0, 0, 16'h0, 0);
    step(0, 1, 16'h0, 0, 16'h0, 0);
    pc = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      step(0, 1, d, 0, 16'h0, 0);
      n_tot++; if (obs_addr !== pc || f1.if_instr !== d || f1.PC_n !== pc + 16'd2 || f1.if_valid !== 1'b1)
        $display("FAIL b2b[%0d] got=%h/%h/%h exp=%h/%h/%h", i, obs_addr, f1.if_instr, f1.PC_n, pc, d, pc + 16'd2); else n_pass++;
      pc = pc + 16'd2;
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    step(1, 0, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0), 16'($urandom),
           ($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 2) == 0));
      n_tot++;
      if (obs_req !== exp_req || (exp_req && obs_addr !== exp_addr)) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_req[%0d] got=%0b/%h exp=%0b/%h", i, obs_req, obs_addr, exp_req, exp_addr);
      end else n_pass++;
      n_tot++;
      if (f1.if_valid !== m_valid || (m_valid && (f1.if_instr !== m_instr || f1.PC_n !== m_pcn))) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_out[%0d] got=%0b/%h/%h exp=%0b/%h/%h", i, f1.if_valid, f1.if_instr, f1.PC_n, m_valid, m_instr, m_pcn);
      end else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_tot++;
      if (fc1 !== 16'(m_fcnt) || sc1 !== 16'(m_scnt)) begin
        errs++;
        if (errs < 10) $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, fc1, sc1, m_fcnt, m_scnt);
      end else n_pass++;
`endif
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    step(1, 0, 16'h0, 0, 16'h0, 0);
    n_tot++; if (fc1 !== 16'd0 || sc1 !== 16'd0) $display("FAIL perf_rst got=%0d/%0d exp=0/0", fc1, sc1); else n_pass++;
    step(0, 1, 16'h0, 0, 16'h0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 16'($urandom), 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 16'($urandom), 0, 16'h0, 1);
    step(0, 1, 16'($urandom), 1, 16'h0100, 0);
    n_tot++; if (fc1 !== 16'd10 || sc1 !== 16'd3) $display("FAIL perf_cnt got=%0d/%0d exp=10/3", fc1, sc1); else n_pass++;
    step(0, 1, 16'($urandom), 0, 16'h0, 0);
    for (int i = 0; i < 65540; i++) step(0, 1, 16'h0, 0, 16'h0, 1);
    n_tot++; if (sc1 !== 16'hFFFF || fc1 !== 16'd11) $display("FAIL perf_sat got=%h/%0d exp=ffff/11", sc1, fc1); else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b1; t_ready = 1'b0; t_data = 16'h0; t_br = 1'b0; t_tgt = 16'h0; t_stall = 1'b0;
    test_reset();
    test_seq();
    test_ready_low();
    test_stall();
    test_branch();
    test_wrap();
    test_reset_midflight();
    test_back_to_back();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
